// File: rtl/apb_decode_mux.sv
// ---------------------------------------------------------------------------
// apb_decode_mux
//   APB3 one-to-N interconnect. Decodes PADDR into a one-hot completer select,
//   returns the selected completer's PRDATA/PREADY/PSLVERR to the requester,
//   answers unmapped addresses with an immediate error, and keeps a saturating
//   count of error completions.
//
//   Address map: completer i owns PADDR range [i*2^SLOT_LSB, (i+1)*2^SLOT_LSB).
//   Anything at or above NUM_SLAVES*2^SLOT_LSB is unmapped.
//
//   Optional feature: define APB_TIMEOUT_EN to force an error completion after
//   TIMEOUT stalled ACCESS cycles. Without it a stalled completer holds the bus.
//
// Ports
//   PCLK       in   bus clock, all state on rising edge
//   PRESET     in   synchronous reset, active-high
//   PSEL       in   requester select
//   PENABLE    in   requester enable
//   PADDR      in   requester address            [ADDRWIDTH]
//   PRDATA     out  read data to requester       [DATAWIDTH]
//   PREADY     out  transfer complete
//   PSLVERR    out  transfer error
//   PSELx      out  one-hot completer selects    [NUM_SLAVES]
//   PENABLEx   out  enable to completers
//   PRDATAx    in   flattened completer read data, slave i at [i*DATAWIDTH +: DATAWIDTH]
//   PREADYx    in   completer ready              [NUM_SLAVES]
//   PSLVERRx   in   completer error              [NUM_SLAVES]
//   ERR_COUNT  out  saturating count of completions with PSLVERR=1 [8]
// ---------------------------------------------------------------------------
module apb_decode_mux #(
    parameter int DATAWIDTH  = 32,
    parameter int ADDRWIDTH  = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLOT_LSB   = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    input  logic [ADDRWIDTH-1:0]            PADDR,
    output logic [DATAWIDTH-1:0]            PRDATA,
    output logic                            PREADY,
    output logic                            PSLVERR,
    output logic [NUM_SLAVES-1:0]           PSELx,
    output logic                            PENABLEx,
    input  logic [NUM_SLAVES*DATAWIDTH-1:0] PRDATAx,
    input  logic [NUM_SLAVES-1:0]           PREADYx,
    input  logic [NUM_SLAVES-1:0]           PSLVERRx,
    output logic [7:0]                      ERR_COUNT
);

    localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int HI_LSB   = SLOT_LSB + SEL_BITS;

    if ((NUM_SLAVES < 1) || (NUM_SLAVES > 16) || (TIMEOUT < 1)) begin : g_param_check
        $error("apb_decode_mux: NUM_SLAVES must be 1..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                state_q;
    state_e                cur_state;
    logic [SEL_BITS-1:0]   idx_q;
    logic                  mapped_q;
    logic [7:0]            err_cnt_q;

    // Live decode of PADDR, used only during the setup phase.
    logic [SEL_BITS-1:0]   dec_idx;
    logic                  dec_mapped;

    assign dec_idx    = PADDR[SLOT_LSB +: SEL_BITS];
    assign dec_mapped = (int'(dec_idx) < NUM_SLAVES) && ((PADDR >> HI_LSB) == '0);

    // Completer response selected by the latched index.
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATAWIDTH-1:0]  sel_rdata;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; that is what keeps these blocks free of inferred latches.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(idx_q) == i) begin
                sel_ready = PREADYx[i];
                sel_err   = PSLVERRx[i];
                sel_rdata = PRDATAx[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // SETUP is recognised from the live PSEL/PENABLE while the registered state
    // is IDLE, so the select is driven in the requester's own setup cycle and a
    // back-to-back transfer after a completion needs no dead cycle. Reset forces
    // IDLE combinationally so every output is quiet while PRESET is high.
    always_comb begin
        cur_state = IDLE;
        if (!PRESET) begin
            if (state_q == ACCESS) begin
                cur_state = PSEL ? ACCESS : IDLE;   // PSEL low here is an abort
            end else if (PSEL && !PENABLE) begin
                cur_state = SETUP;                  // PENABLE high in IDLE is ignored
            end
        end
    end

    logic timeout_hit;

`ifdef APB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] stall_q;

    assign timeout_hit = (cur_state == ACCESS) && mapped_q && (stall_q == TW'(TIMEOUT));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            stall_q <= '0;
        end else if (cur_state == SETUP) begin
            stall_q <= '0;
        end else if ((cur_state == ACCESS) && mapped_q && !sel_ready && !timeout_hit) begin
            stall_q <= stall_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        PSELx    = '0;
        PENABLEx = 1'b0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        PRDATA   = '0;
        unique case (cur_state)
            SETUP: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    PSELx[i] = dec_mapped && (int'(dec_idx) == i);
                end
            end
            ACCESS: begin
                if (!mapped_q || timeout_hit) begin
                    // Interconnect-generated error completion; no completer selected.
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_SLAVES; i++) begin
                        PSELx[i] = (int'(idx_q) == i);
                    end
                    PENABLEx = PENABLE;
                    PREADY   = sel_ready;
                    PSLVERR  = sel_err & sel_ready;
                    PRDATA   = sel_rdata;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous, checked first inside the edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mapped_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            unique case (cur_state)
                SETUP: begin
                    state_q  <= ACCESS;
                    idx_q    <= dec_idx;
                    mapped_q <= dec_mapped;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (PREADY && PSLVERR && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign ERR_COUNT = err_cnt_q;

endmodule
